// File: rtl/axil_pkg.sv
// Shared response codes and FSM state encodings for the AXI4-Lite register slave.
package axil_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_t;

  typedef enum logic [1:0] {
    W_IDLE      = 2'b00,
    W_HAVE_ADDR = 2'b01,
    W_HAVE_DATA = 2'b10,
    W_RESP      = 2'b11
  } w_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_t;

endpackage

// File: rtl/axil_if.sv
// AXI4-Lite bus bundle; WSTRB exists only when AXIL_WSTRB_EN is defined.
interface axil_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   AWADDR;
  logic                AWVALID;
  logic                AWREADY;
  logic [DATA_W-1:0]   WDATA;
`ifdef AXIL_WSTRB_EN
  logic [DATA_W/8-1:0] WSTRB;
`endif
  logic                WVALID;
  logic                WREADY;
  logic [1:0]          BRESP;
  logic                BVALID;
  logic                BREADY;
  logic [ADDR_W-1:0]   ARADDR;
  logic                ARVALID;
  logic                ARREADY;
  logic [DATA_W-1:0]   RDATA;
  logic [1:0]          RRESP;
  logic                RVALID;
  logic                RREADY;

  modport master (
    output AWADDR, AWVALID, WDATA, WVALID, BREADY, ARADDR, ARVALID, RREADY,
`ifdef AXIL_WSTRB_EN
    output WSTRB,
`endif
    input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );

  modport slave (
    input  AWADDR, AWVALID, WDATA, WVALID, BREADY, ARADDR, ARVALID, RREADY,
`ifdef AXIL_WSTRB_EN
    input  WSTRB,
`endif
    output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );
endinterface

// File: rtl/axil_regfile.sv
// Register array with byte-strobe merge and one-cycle write pulses.
module axil_regfile
  import axil_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 4,
  parameter int IDX_W    = 2
) (
  input  logic                       ACLK,
  input  logic                       ARESETn,
  input  logic                       wr_en,
  input  logic [IDX_W-1:0]           wr_idx,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic [DATA_W/8-1:0]        wr_strb,
  output logic [NUM_REGS*DATA_W-1:0] regs_flat,
  output logic [NUM_REGS-1:0]        wr_pulse
);

  logic [NUM_REGS*DATA_W-1:0] regs_r;
  logic [NUM_REGS-1:0]        pulse_r;

  function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0]   old_v,
                                                    input logic [DATA_W-1:0]   new_v,
                                                    input logic [DATA_W/8-1:0] strb);
    logic [DATA_W-1:0] res;
    for (int b = 0; b < DATA_W/8; b++) begin
      res[b*8 +: 8] = strb[b] ? new_v[b*8 +: 8] : old_v[b*8 +: 8];
    end
    return res;
  endfunction

  // Register storage and write pulse generation
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      regs_r  <= {(NUM_REGS*DATA_W){1'b0}};
      pulse_r <= {NUM_REGS{1'b0}};
    end else begin
      pulse_r <= {NUM_REGS{1'b0}};
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_en && (wr_idx == IDX_W'(i))) begin
          regs_r[i*DATA_W +: DATA_W] <= merge_bytes(regs_r[i*DATA_W +: DATA_W], wr_data, wr_strb);
          pulse_r[i]                 <= 1'b1;
        end
      end
    end
  end

  assign regs_flat = regs_r;
  assign wr_pulse  = pulse_r;

endmodule

// File: rtl/axil_reg_slave.sv
// AXI4-Lite register slave: independent write and read handshake FSMs around axil_regfile.
// Optional byte strobes are enabled with the AXIL_WSTRB_EN macro.
module axil_reg_slave
  import axil_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 4,
  parameter int ADDR_W   = 4
) (
  input  logic                       ACLK,
  input  logic                       ARESETn,
  axil_if.slave                      s_axil,
  output logic [NUM_REGS*DATA_W-1:0] regs_o,
  output logic [NUM_REGS-1:0]        wr_pulse_o
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int IDX_W  = ADDR_W - OFF_W;

  // Extra top bit so NUM_REGS == 2**IDX_W still compares correctly
  function automatic logic idx_ok(input logic [IDX_W-1:0] idx);
    return ({1'b0, idx} < (IDX_W+1)'(NUM_REGS));
  endfunction

  w_state_t            w_state_r, w_next_s;
  logic [IDX_W-1:0]    aw_idx_r, aw_idx_in_s, cm_idx_s;
  logic [DATA_W-1:0]   wdata_r, cm_data_s;
  logic [STRB_W-1:0]   wstrb_r, wstrb_in_s, cm_strb_s;
  resp_t               bresp_r;
  logic                aw_rdy_s, w_rdy_s, aw_hs_s, w_hs_s;
  logic                latch_aw_s, latch_w_s, commit_s;

  r_state_t            r_state_r, r_next_s;
  logic [IDX_W-1:0]    ar_idx_s;
  logic [DATA_W-1:0]   rd_word_s, rdata_r;
  resp_t               rresp_r;
  logic                ar_rdy_s, ar_hs_s;
  logic [NUM_REGS*DATA_W-1:0] regs_flat_s;

`ifdef AXIL_WSTRB_EN
  assign wstrb_in_s = s_axil.WSTRB;
`else
  assign wstrb_in_s = {STRB_W{1'b1}};
`endif

  assign aw_idx_in_s = s_axil.AWADDR[ADDR_W-1:OFF_W];
  assign aw_rdy_s    = ARESETn && ((w_state_r == W_IDLE) || (w_state_r == W_HAVE_DATA));
  assign w_rdy_s     = ARESETn && ((w_state_r == W_IDLE) || (w_state_r == W_HAVE_ADDR));
  assign aw_hs_s     = s_axil.AWVALID && aw_rdy_s;
  assign w_hs_s      = s_axil.WVALID && w_rdy_s;

  // Write FSM next state; the commit takes whichever half is arriving live
  always_comb begin
    w_next_s   = w_state_r;
    latch_aw_s = 1'b0;
    latch_w_s  = 1'b0;
    commit_s   = 1'b0;
    cm_idx_s   = aw_idx_r;
    cm_data_s  = wdata_r;
    cm_strb_s  = wstrb_r;
    case (w_state_r)
      W_IDLE: begin
        if (aw_hs_s && w_hs_s) begin
          w_next_s  = W_RESP;
          commit_s  = 1'b1;
          cm_idx_s  = aw_idx_in_s;
          cm_data_s = s_axil.WDATA;
          cm_strb_s = wstrb_in_s;
        end else if (aw_hs_s) begin
          w_next_s   = W_HAVE_ADDR;
          latch_aw_s = 1'b1;
        end else if (w_hs_s) begin
          w_next_s  = W_HAVE_DATA;
          latch_w_s = 1'b1;
        end else begin
          w_next_s = W_IDLE;
        end
      end
      W_HAVE_ADDR: begin
        if (w_hs_s) begin
          w_next_s  = W_RESP;
          commit_s  = 1'b1;
          cm_data_s = s_axil.WDATA;
          cm_strb_s = wstrb_in_s;
        end else begin
          w_next_s = W_HAVE_ADDR;
        end
      end
      W_HAVE_DATA: begin
        if (aw_hs_s) begin
          w_next_s = W_RESP;
          commit_s = 1'b1;
          cm_idx_s = aw_idx_in_s;
        end else begin
          w_next_s = W_HAVE_DATA;
        end
      end
      W_RESP: begin
        if (s_axil.BREADY) begin
          w_next_s = W_IDLE;
        end else begin
          w_next_s = W_RESP;
        end
      end
      default: w_next_s = W_IDLE;
    endcase
  end

  // Write FSM state, half-transaction holding registers and response code
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      w_state_r <= W_IDLE;
      aw_idx_r  <= {IDX_W{1'b0}};
      wdata_r   <= {DATA_W{1'b0}};
      wstrb_r   <= {STRB_W{1'b0}};
      bresp_r   <= OKAY;
    end else begin
      w_state_r <= w_next_s;
      if (latch_aw_s) aw_idx_r <= aw_idx_in_s;
      if (latch_w_s) begin
        wdata_r <= s_axil.WDATA;
        wstrb_r <= wstrb_in_s;
      end
      if (commit_s) bresp_r <= idx_ok(cm_idx_s) ? OKAY : SLVERR;
    end
  end

  axil_regfile #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .IDX_W    (IDX_W)
  ) u_regfile (
    .ACLK      (ACLK),
    .ARESETn   (ARESETn),
    .wr_en     (commit_s && idx_ok(cm_idx_s)),
    .wr_idx    (cm_idx_s),
    .wr_data   (cm_data_s),
    .wr_strb   (cm_strb_s),
    .regs_flat (regs_flat_s),
    .wr_pulse  (wr_pulse_o)
  );

  assign ar_idx_s = s_axil.ARADDR[ADDR_W-1:OFF_W];
  assign ar_rdy_s = ARESETn && (r_state_r == R_IDLE);
  assign ar_hs_s  = s_axil.ARVALID && ar_rdy_s;

  // Read mux as an OR of masked words so an out-of-range index yields zero
  always_comb begin
    rd_word_s = {DATA_W{1'b0}};
    for (int i = 0; i < NUM_REGS; i++) begin
      rd_word_s = rd_word_s | (regs_flat_s[i*DATA_W +: DATA_W] & {DATA_W{ar_idx_s == IDX_W'(i)}});
    end
  end

  // Read FSM next state
  always_comb begin
    r_next_s = r_state_r;
    case (r_state_r)
      R_IDLE: begin
        if (ar_hs_s) r_next_s = R_DATA;
        else         r_next_s = R_IDLE;
      end
      R_DATA: begin
        if (s_axil.RREADY) r_next_s = R_IDLE;
        else               r_next_s = R_DATA;
      end
      default: r_next_s = R_IDLE;
    endcase
  end

  // Read FSM state and registered read response
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      r_state_r <= R_IDLE;
      rdata_r   <= {DATA_W{1'b0}};
      rresp_r   <= OKAY;
    end else begin
      r_state_r <= r_next_s;
      if (ar_hs_s) begin
        rdata_r <= idx_ok(ar_idx_s) ? rd_word_s : {DATA_W{1'b0}};
        rresp_r <= idx_ok(ar_idx_s) ? OKAY : SLVERR;
      end
    end
  end

  assign s_axil.AWREADY = aw_rdy_s;
  assign s_axil.WREADY  = w_rdy_s;
  assign s_axil.BVALID  = (w_state_r == W_RESP);
  assign s_axil.BRESP   = bresp_r;
  assign s_axil.ARREADY = ar_rdy_s;
  assign s_axil.RVALID  = (r_state_r == R_DATA);
  assign s_axil.RDATA   = rdata_r;
  assign s_axil.RRESP   = rresp_r;
  assign regs_o         = regs_flat_s;

endmodule

// File: tb/tb_axil_reg_slave.sv
// Directed plus randomized bench for axil_reg_slave against an array-based register model.
module tb_axil_reg_slave;

  localparam int DW = 32;
  localparam int NR = 4;
  localparam int AW = 5;

  logic ACLK = 1'b0;
  logic ARESETn;
  logic [NR*DW-1:0] regs_o;
  logic [NR-1:0]    wr_pulse_o;

  always #5 ACLK = ~ACLK;

  axil_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  axil_reg_slave #(.DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW)) dut (
    .ACLK       (ACLK),
    .ARESETn    (ARESETn),
    .s_axil     (bus.slave),
    .regs_o     (regs_o),
    .wr_pulse_o (wr_pulse_o)
  );

  int tests = 0;
  int fails = 0;
  logic [31:0] model [NR];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] model_flat();
    logic [127:0] f;
    for (int i = 0; i < NR; i++) f[i*32 +: 32] = model[i];
    return f;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] m;
    m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (old_v & ~m) | (d & m);
  endfunction

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic set_strb(input logic [3:0] s);
`ifdef AXIL_WSTRB_EN
    bus.WSTRB = s;
`else
    if (s == 4'h0) bus.WDATA = bus.WDATA;
`endif
  endtask

  task automatic send_aw(input logic [4:0] a);
    bit got = 1'b0;
    bus.AWADDR  = a;
    bus.AWVALID = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge ACLK);
      got = bus.AWREADY;
    end
    check("aw_accept", got, 1);
    tick();
    bus.AWVALID = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s);
    bit got = 1'b0;
    bus.WDATA  = d;
    set_strb(s);
    bus.WVALID = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge ACLK);
      got = bus.WREADY;
    end
    check("w_accept", got, 1);
    tick();
    bus.WVALID = 1'b0;
  endtask

  task automatic send_both(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
    bit got = 1'b0;
    bus.AWADDR  = a;
    bus.WDATA   = d;
    set_strb(s);
    bus.AWVALID = 1'b1;
    bus.WVALID  = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge ACLK);
      got = bus.AWREADY && bus.WREADY;
    end
    check("aw_w_accept", got, 1);
    tick();
    bus.AWVALID = 1'b0;
    bus.WVALID  = 1'b0;
  endtask

  // Called right after the commit edge: updates the model and checks the response phase.
  task automatic finish_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s, input int bdelay);
    int          idx = int'(a[4:2]);
    bit          ok  = (idx < NR);
    logic [3:0]  es;
    logic [1:0]  er;
`ifdef AXIL_WSTRB_EN
    es = s;
`else
    es = 4'hF;
`endif
    if (ok) model[idx] = merge(model[idx], d, es);
    er = ok ? 2'b00 : 2'b10;
    check("bvalid_after_commit", bus.BVALID, 1);
    check("bresp", bus.BRESP, er);
    check("wr_pulse", wr_pulse_o, ok ? (4'b0001 << idx) : 4'b0000);
    check("regs_after_write", regs_o, model_flat());
    for (int k = 0; k < bdelay; k++) begin
      tick();
      check("bvalid_hold", bus.BVALID, 1);
      check("bresp_hold", bus.BRESP, er);
      check("awready_in_resp", bus.AWREADY, 0);
      check("wready_in_resp", bus.WREADY, 0);
      check("pulse_single", wr_pulse_o, 0);
    end
    bus.BREADY = 1'b1;
    tick();
    bus.BREADY = 1'b0;
    check("bvalid_clear", bus.BVALID, 0);
    check("pulse_clear", wr_pulse_o, 0);
    check("awready_back", bus.AWREADY, 1);
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s, input int order, input int bdelay);
    case (order)
      1: begin send_aw(a); send_w(d, s); end
      2: begin send_w(d, s); send_aw(a); end
      default: send_both(a, d, s);
    endcase
    finish_write(a, d, s, bdelay);
  endtask

  task automatic send_ar(input logic [4:0] a);
    bit got = 1'b0;
    bus.ARADDR  = a;
    bus.ARVALID = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge ACLK);
      got = bus.ARREADY;
    end
    check("ar_accept", got, 1);
    tick();
    bus.ARVALID = 1'b0;
  endtask

  task automatic do_read(input logic [4:0] a, input int rdelay);
    int idx = int'(a[4:2]);
    bit ok  = (idx < NR);
    logic [31:0] exp_d;
    exp_d = ok ? model[idx] : 32'h0;
    send_ar(a);
    check("rvalid", bus.RVALID, 1);
    check("rdata", bus.RDATA, exp_d);
    check("rresp", bus.RRESP, ok ? 2'b00 : 2'b10);
    for (int k = 0; k < rdelay; k++) begin
      tick();
      check("rdata_hold", bus.RDATA, exp_d);
      check("arready_in_data", bus.ARREADY, 0);
    end
    bus.RREADY = 1'b1;
    tick();
    bus.RREADY = 1'b0;
    check("rvalid_clear", bus.RVALID, 0);
  endtask

  task automatic check_reset_outputs();
    check("rst_awready", bus.AWREADY, 0);
    check("rst_wready", bus.WREADY, 0);
    check("rst_arready", bus.ARREADY, 0);
    check("rst_bvalid", bus.BVALID, 0);
    check("rst_rvalid", bus.RVALID, 0);
    check("rst_rdata", bus.RDATA, 0);
    check("rst_regs", regs_o, 0);
    check("rst_pulse", wr_pulse_o, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] old_v;
    ARESETn     = 1'b0;
    bus.AWADDR  = 5'h0;  bus.AWVALID = 1'b0;
    bus.WDATA   = 32'h0; bus.WVALID  = 1'b0;
    bus.BREADY  = 1'b0;
    bus.ARADDR  = 5'h0;  bus.ARVALID = 1'b0;
    bus.RREADY  = 1'b0;
    set_strb(4'hF);
    for (int i = 0; i < NR; i++) model[i] = 32'h0;

    repeat (3) tick();
    check_reset_outputs();
    ARESETn = 1'b1;
    #1;
    check("release_awready", bus.AWREADY, 1);
    check("release_wready", bus.WREADY, 1);
    check("release_arready", bus.ARREADY, 1);

    // Basic write then read-back of every register
    for (int i = 0; i < NR; i++) do_write(5'(i * 4), 32'(i + 1), 4'hF, 0, 0);
    for (int i = 0; i < NR; i++) do_read(5'(i * 4), 0);
    check("basic_reg3", regs_o[127:96], 32'h4);

    // W accepted two cycles ahead of AW, then BREADY withheld for 5 cycles
    send_w(32'hDEADBEEF, 4'hF);
    check("w_first_wready", bus.WREADY, 0);
    check("w_first_awready", bus.AWREADY, 1);
    check("w_first_no_bvalid", bus.BVALID, 0);
    check("w_first_no_commit", regs_o[63:32], 32'h2);
    tick();
    tick();
    send_aw(5'h04);
    check("reg1_deadbeef", regs_o[63:32], 32'hDEADBEEF);
    finish_write(5'h04, 32'hDEADBEEF, 4'hF, 5);

    // Out-of-range address
    do_write(5'h10, 32'hCAFEF00D, 4'hF, 0, 1);
    do_read(5'h10, 1);
    do_read(5'h1F, 0);

`ifdef AXIL_WSTRB_EN
    do_write(5'h00, 32'h11223344, 4'hF, 0, 0);
    do_write(5'h00, 32'hAABBCCDD, 4'b0101, 1, 0);
    check("strb_merge", regs_o[31:0], 32'h11BB33DD);
    do_write(5'h00, 32'hFFFFFFFF, 4'b0000, 2, 0);
    check("strb_zero", regs_o[31:0], 32'h11BB33DD);
`endif

    // Read and write to the same register handshake on the same edge
    old_v       = model[2];
    bus.AWADDR  = 5'h08; bus.WDATA = 32'h5A5A1234; set_strb(4'hF);
    bus.ARADDR  = 5'h08;
    bus.AWVALID = 1'b1; bus.WVALID = 1'b1; bus.ARVALID = 1'b1;
    @(negedge ACLK);
    check("same_edge_ready", {bus.AWREADY, bus.WREADY, bus.ARREADY}, 3'b111);
    tick();
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0; bus.ARVALID = 1'b0;
    check("same_edge_rdata_old", bus.RDATA, old_v);
    finish_write(5'h08, 32'h5A5A1234, 4'hF, 0);
    bus.RREADY = 1'b1;
    tick();
    bus.RREADY = 1'b0;
    check("same_edge_rvalid_clear", bus.RVALID, 0);

    // Reset while holding only the write address
    send_aw(5'h04);
    check("have_addr_awready", bus.AWREADY, 0);
    check("have_addr_wready", bus.WREADY, 1);
    ARESETn = 1'b0;
    tick();
    check_reset_outputs();
    tick();
    ARESETn = 1'b1;
    #1;
    check("rerelease_awready", bus.AWREADY, 1);
    check("rerelease_wready", bus.WREADY, 1);
    for (int i = 0; i < NR; i++) model[i] = 32'h0;
    send_w(32'h12345678, 4'hF);
    for (int k = 0; k < 3; k++) begin
      check("no_commit_after_reset_bvalid", bus.BVALID, 0);
      check("no_commit_after_reset_regs", regs_o, 0);
      tick();
    end
    send_aw(5'h0C);
    finish_write(5'h0C, 32'h12345678, 4'hF, 0);

    // Randomized mix against the model
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 1) == 0) begin
        do_write(5'($urandom_range(0, 31)), $urandom, 4'($urandom_range(0, 15)),
                 int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
      end else begin
        do_read(5'($urandom_range(0, 31)), int'($urandom_range(0, 3)));
      end
    end
    check("final_regs", regs_o, model_flat());

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/axil_reg_slave.md
AXIL_REG_SLAVE -- requirements
Module: axil_reg_slave

Interface
REQ-001 SHALL have parameter DATA_W, default 32, the register and bus data width; legal values are 32 and 64.
REQ-002 SHALL have parameter NUM_REGS, default 4, the register count; legal range is 1..256.
REQ-003 SHALL have parameter ADDR_W, default 4, the byte-address width; it SHALL be at least clog2(NUM_REGS)+clog2(DATA_W/8).
REQ-004 SHALL use one clock and a synchronous, active-low reset: ACLK  in  1  clock; ARESETn  in  1  synchronous active-low reset.
REQ-005 SHALL provide the write-address channel: AWADDR  in  ADDR_W; AWVALID  in  1; AWREADY  out  1.
REQ-006 SHALL provide the write-data channel: WDATA  in  DATA_W; WSTRB  in  DATA_W/8 (present only under AXIL_WSTRB_EN); WVALID  in  1; WREADY  out  1.
REQ-007 SHALL provide the write-response channel: BRESP  out  2; BVALID  out  1; BREADY  in  1.
REQ-008 SHALL provide the read-address channel: ARADDR  in  ADDR_W; ARVALID  in  1; ARREADY  out  1.
REQ-009 SHALL provide the read-data channel: RDATA  out  DATA_W; RRESP  out  2; RVALID  out  1; RREADY  in  1.
REQ-010 SHALL provide the register outputs: regs_o  out  NUM_REGS*DATA_W  flat image of all registers, with reg i at bits [i*DATA_W +: DATA_W]; wr_pulse_o  out  NUM_REGS  one-cycle pulse per committed register write.

Function
REQ-011 Register index SHALL be addr[ADDR_W-1:clog2(DATA_W/8)]; the low byte-offset bits are ignored.
REQ-012 Write FSM states SHALL be W_IDLE, W_HAVE_ADDR, W_HAVE_DATA and W_RESP.
REQ-013 Write FSM transitions: W_IDLE goes to W_RESP if AW and W handshake in the same cycle, otherwise to W_HAVE_ADDR or W_HAVE_DATA; each W_HAVE_* state goes to W_RESP on the missing handshake; W_RESP goes to W_IDLE on BVALID&&BREADY.
REQ-014 AWREADY SHALL be high only in W_IDLE and W_HAVE_DATA; WREADY SHALL be high only in W_IDLE and W_HAVE_ADDR; neither READY SHALL depend combinationally on VALID.
REQ-015 A write SHALL commit on the clock edge where the second handshake completes; the register and wr_pulse_o[idx] update at that edge, and BVALID=1 from the next cycle.
REQ-016 BVALID, BRESP and the FSM state SHALL hold stable until BREADY; no new AW or W SHALL be accepted in W_RESP.
REQ-017 If idx < NUM_REGS, BRESP SHALL be 2'b00 (OKAY); otherwise BRESP SHALL be 2'b10 (SLVERR), no register changes and no pulse is generated.
REQ-018 Read FSM states SHALL be R_IDLE (ARREADY=1) and R_DATA (RVALID=1, ARREADY=0).
REQ-019 On the AR handshake, RDATA and RRESP SHALL be registered at that edge, giving RVALID in the next cycle (1-cycle latency); the FSM SHALL return to R_IDLE on RVALID&&RREADY.
REQ-020 An out-of-range read SHALL return RDATA=0 and RRESP=2'b10.
REQ-021 If a read and a write to the same register complete on the same edge, the read SHALL return the pre-write value.
REQ-022 The read and write paths SHALL be fully independent; neither SHALL stall the other.

Reset
REQ-023 While ARESETn=0 at a rising edge: all registers, RDATA, regs_o and wr_pulse_o SHALL be 0; BVALID and RVALID SHALL be 0; both FSMs SHALL return to idle.
REQ-024 A reset mid-transaction SHALL discard any partially latched AW/W and any pending response; no register write SHALL occur.
REQ-025 AWREADY, WREADY and ARREADY SHALL be 0 while ARESETn=0, and SHALL be 1 in the first cycle after release.

Configuration
REQ-026 With AXIL_WSTRB_EN defined, the WSTRB port SHALL exist and byte lane b SHALL be written only if WSTRB[b]=1; WSTRB=0 still commits, returns OKAY and pulses wr_pulse_o.
REQ-027 Without AXIL_WSTRB_EN, the WSTRB port SHALL be absent and every write SHALL update the full word.

Structure
REQ-028 Package axil_pkg SHALL hold the resp_t codes (OKAY=2'b00, SLVERR=2'b10) and the write and read FSM state enums.
REQ-029 The register array and the strobe merge SHALL live in sub-module axil_regfile; the handshake FSMs SHALL live in axil_reg_slave.

Verification
REQ-030 Reset, then write 0x0/1, 0x4/2, 0x8/3, 0xC/4, then read 0x0..0xC -> RDATA 1,2,3,4, all RRESP=OKAY, and wr_pulse_o pulses once per write.
REQ-031 Present W two cycles before AW (addr 0x4, data 0xDEADBEEF) -> W accepted first; commit on the AW edge; BVALID the next cycle; regs_o reg1=0xDEADBEEF.
REQ-032 Hold BREADY=0 for 5 cycles after BVALID -> BVALID and BRESP stable; AWREADY=WREADY=0 throughout.
REQ-033 With NUM_REGS=4, ADDR_W=5, write and read 0x10 -> BRESP=SLVERR, RRESP=SLVERR, RDATA=0, no register change.
REQ-034 Under AXIL_WSTRB_EN, reg0=0x11223344, write 0xAABBCCDD with WSTRB=4'b0101 -> reg0=0x11BB33DD.
REQ-035 Assert ARESETn=0 while in W_HAVE_ADDR -> after release no write commits, BVALID=0 and all registers are 0.
